cpu_core_mc: RTL and testbench
==============================

// Module: cpu_core_mc
// PURPOSE
//  Parametrised multi-cycle CPU core. States: FETCH/DECODE/EXECUTE/MEMACC/WRITEBACK/HALT.
//  Instructions arrive from the instruction source as {opcode,data1,data2} over a valid/ready
//  handshake, addressed by o_pc. Loads/stores go through a req/ready memory port.
//  Generalises the 8-bit core: DATA_W, NREGS and ADDR_W are parameters; adds ALU flags,
//  branch, call/return, memory write and halt.
// PARAMETERS
//  DATA_W  8   register/ALU/memory data width (>=8)
//  NREGS   8   general registers R0..NREGS-1 (2..16)
//  ADDR_W  16  PC, RA and memory address width (<=16)
// PORTS
//  i_clk          in   1       clock, all state on rising edge
//  i_rst_n        in   1       reset
//  i_hold         in   1       stall: blocks instruction accept in FETCH only
//  i_instr_valid  in   1       instruction fields valid
//  o_instr_ready  out  1       core accepts instruction this cycle
//  i_opcode       in   8       [7:4] op, [3:0] rd index
//  i_data1        in   8       rs index / immediate / address low byte
//  i_data2        in   8       address high byte
//  o_pc           out  ADDR_W  address of the next instruction to fetch
//  o_mem_req      out  1       memory access request
//  o_mem_we       out  1       1=store, 0=load; valid while o_mem_req
//  o_mem_addr     out  ADDR_W  memory address
//  o_mem_wdata    out  DATA_W  store data
//  i_mem_ready    in   1       access completes this cycle
//  i_mem_rdata    in   DATA_W  load data; sampled when o_mem_req && i_mem_ready
//  o_wait         out  1       core busy (state != FETCH)
//  o_halted       out  1       core in HALT
//  o_data         out  DATA_W  output port register
// BEHAVIOUR
//  Clock and reset: one clock; reset is asynchronous and active-low.
//  Reset: state=FETCH, PC=0, RA=0, all Rn=0, Z=C=0, o_data=0, o_mem_req=0, o_wait=0, o_halted=0.
//   Reset asserted mid-instruction aborts it immediately; o_mem_req drops asynchronously.
//  FETCH: o_instr_ready = !i_hold. Accept when i_instr_valid && o_instr_ready: latch fields,
//   go to DECODE. Otherwise stay in FETCH. i_hold is ignored outside FETCH.
//  DECODE (1 cycle) -> EXECUTE (1 cycle). From EXECUTE, LD/ST go to MEMACC; all others go to WRITEBACK.
//  MEMACC: o_mem_req=1, o_mem_addr/we/wdata held stable until i_mem_ready. Then WRITEBACK.
//  WRITEBACK: commit the Rn write. PC <= target if branch taken, else PC+1 (wraps mod 2^ADDR_W).
//   Then go to FETCH.
//  Latency from accept to the next FETCH: 4 cycles for non-memory ops; 4+N cycles for LD/ST,
//   where N>=1 is the number of MEMACC cycles.
//  Operands: addr = {data2,data1} truncated to ADDR_W; imm = data1 zero-extended to DATA_W;
//   rs = data1[3:0].
//  Ops: 0 NOP | 1 LDI Rd=imm | 2 MOV Rd=Rs | 3 ADD Rd=Rd+Rs | 4 SUB Rd=Rd-Rs
//   5 AND | 6 OR | 7 XOR (Rd=Rd op Rs) | 8 LD Rd=mem[addr] | 9 ST mem[addr]=Rd
//   A OUT o_data=Rd | B JMP PC=addr | C JZ PC=addr if Z | D CALL RA=PC+1, PC=addr
//   E RET PC=RA | F HALT.
//  Arithmetic and flags:
//   ADD/SUB wrap mod 2^DATA_W. C = carry out (ADD) or borrow (SUB).
//   Z = (result==0) for ops 3-7. Flags are otherwise unchanged.
//  Register indices: rd or rs >= NREGS makes the op a NOP that still advances the PC
//   (no write, no memory access, flags unchanged).
//  HALT: enter HALT after WRITEBACK without advancing the PC. o_halted=1, o_wait=1,
//   o_instr_ready=0. Only reset exits HALT.
//  CALL nesting: single-level (RA only). A nested CALL overwrites RA.
// TESTING
//  1 Reset -> o_pc=0, o_wait=0, o_instr_ready=1, o_mem_req=0, o_data=0.
//  2 LDI R1,0xFF; LDI R2,0x01; ADD R1,R2; OUT R1 -> o_data=0x00, Z=1, C=1; each op 4 cycles.
//  3 ST R1->0x0010 with i_mem_ready delayed 3 cycles -> req/addr/we/wdata held stable for all
//    3 cycles; LD R3<-0x0010 -> R3=R1.
//  4 i_hold=1 with i_instr_valid=1 in FETCH -> no accept, o_pc unchanged.
//    i_hold raised during EXECUTE -> instruction completes normally.
//  5 CALL 0x0040 at PC=5 -> PC=0x40, RA=6; RET -> PC=6; JZ with Z=0 -> PC+1.
//  6 i_rst_n low during MEMACC -> o_mem_req=0 same cycle, state FETCH.
//    HALT -> o_halted=1 held until reset.

Source files
------------

// File: rtl/cpu_core_mc_if.sv
// Bus bundle for cpu_core_mc: instruction handshake, memory port and status outputs.
// The slave modport is the core's view; master is the environment driving it.
interface cpu_core_mc_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 16
);
    logic              i_hold;
    logic              i_instr_valid;
    logic              o_instr_ready;
    logic [7:0]        i_opcode;
    logic [7:0]        i_data1;
    logic [7:0]        i_data2;
    logic [ADDR_W-1:0] o_pc;
    logic              o_mem_req;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic              i_mem_ready;
    logic [DATA_W-1:0] i_mem_rdata;
    logic              o_wait;
    logic              o_halted;
    logic [DATA_W-1:0] o_data;

    modport slave (
        input  i_hold, i_instr_valid, i_opcode, i_data1, i_data2, i_mem_ready, i_mem_rdata,
        output o_instr_ready, o_pc, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
        output o_wait, o_halted, o_data
    );

    modport master (
        output i_hold, i_instr_valid, i_opcode, i_data1, i_data2, i_mem_ready, i_mem_rdata,
        input  o_instr_ready, o_pc, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
        input  o_wait, o_halted, o_data
    );
endinterface

// File: rtl/cpu_core_mc.sv
// Multi-cycle CPU core: FETCH -> DECODE -> EXECUTE -> [MEMACC] -> WRITEBACK, plus HALT.
// Operands are read in DECODE, the ALU result and pending flags are formed in EXECUTE,
// and all architectural state (Rn, flags, PC, RA, output port) commits in WRITEBACK.
module cpu_core_mc #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned ADDR_W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    cpu_core_mc_if.slave bus
);
    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_MEMACC    = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_HALT      = 3'd5;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_MOV  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_OUT  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_CALL = 4'hD;
    localparam logic [3:0] OP_RET  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    logic [2:0]        state_q, state_d;
    logic [3:0]        op_q, op_d, rd_q, rd_d;
    logic [7:0]        d1_q, d1_d, d2_q, d2_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic              nop_q, nop_d, zn_q, zn_d, cn_q, cn_d;
    logic [DATA_W-1:0] regs_q [16];
    logic [DATA_W-1:0] regs_d [16];
    logic [ADDR_W-1:0] pc_q, pc_d, ra_q, ra_d;
    logic              z_q, z_d, c_q, c_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic [3:0]        rs;
    logic [ADDR_W-1:0] addr, pc_inc;
    logic [DATA_W:0]   sum, diff;
    logic              uses_rd, uses_rs;

    assign rs     = d1_q[3:0];
    assign addr   = ADDR_W'({d2_q, d1_q});
    assign pc_inc = pc_q + ADDR_W'(1);
    assign sum    = {1'b0, a_q} + {1'b0, b_q};
    assign diff   = {1'b0, a_q} - {1'b0, b_q};
    assign uses_rd = (op_q >= OP_LDI) && (op_q <= OP_OUT);
    assign uses_rs = (op_q >= OP_MOV) && (op_q <= OP_XOR);

    // Next-state: instruction sequencing, ALU and architectural commit
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        nop_d   = nop_q;
        zn_d    = zn_q;
        cn_d    = cn_q;
        regs_d  = regs_q;
        pc_d    = pc_q;
        ra_d    = ra_q;
        z_d     = z_q;
        c_d     = c_q;
        data_d  = data_q;
        case (state_q)
            S_FETCH: begin
                if (bus.i_instr_valid && !bus.i_hold) begin
                    op_d    = bus.i_opcode[7:4];
                    rd_d    = bus.i_opcode[3:0];
                    d1_d    = bus.i_data1;
                    d2_d    = bus.i_data2;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = regs_q[rd_q];
                b_d     = regs_q[rs];
                // Out-of-range register index turns the op into a PC-advancing NOP
                nop_d   = (uses_rd && (32'(rd_q) >= NREGS)) || (uses_rs && (32'(rs) >= NREGS));
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                cn_d = c_q;
                case (op_q)
                    OP_LDI:  res_d = DATA_W'(d1_q);
                    OP_MOV:  res_d = b_q;
                    OP_ADD:  begin res_d = sum[DATA_W-1:0];  cn_d = sum[DATA_W];  end
                    OP_SUB:  begin res_d = diff[DATA_W-1:0]; cn_d = diff[DATA_W]; end
                    OP_AND:  res_d = a_q & b_q;
                    OP_OR:   res_d = a_q | b_q;
                    OP_XOR:  res_d = a_q ^ b_q;
                    default: res_d = a_q;
                endcase
                zn_d    = (res_d == '0);
                state_d = ((op_q == OP_LD || op_q == OP_ST) && !nop_q) ? S_MEMACC : S_WRITEBACK;
            end
            S_MEMACC: begin
                if (bus.i_mem_ready) begin
                    if (op_q == OP_LD) res_d = bus.i_mem_rdata;
                    state_d = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                pc_d    = pc_inc;
                state_d = S_FETCH;
                if (!nop_q) begin
                    case (op_q)
                        OP_LDI, OP_MOV, OP_AND, OP_OR, OP_XOR, OP_LD: regs_d[rd_q] = res_q;
                        OP_ADD, OP_SUB: regs_d[rd_q] = res_q;
                        OP_OUT:  data_d = a_q;
                        OP_JMP:  pc_d = addr;
                        OP_JZ:   if (z_q) pc_d = addr;
                        OP_CALL: begin ra_d = pc_inc; pc_d = addr; end
                        OP_RET:  pc_d = ra_q;
                        OP_HALT: begin pc_d = pc_q; state_d = S_HALT; end
                        default: ;
                    endcase
                    if (uses_rs && op_q != OP_MOV) z_d = zn_q;
                    if (op_q == OP_ADD || op_q == OP_SUB) c_d = cn_q;
                end
            end
            S_HALT: ;
            default: state_d = S_FETCH;
        endcase
    end

    // State registers; reset aborts any instruction in flight
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            rd_q    <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            nop_q   <= 1'b0;
            zn_q    <= 1'b0;
            cn_q    <= 1'b0;
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
            pc_q    <= '0;
            ra_q    <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            nop_q   <= nop_d;
            zn_q    <= zn_d;
            cn_q    <= cn_d;
            regs_q  <= regs_d;
            pc_q    <= pc_d;
            ra_q    <= ra_d;
            z_q     <= z_d;
            c_q     <= c_d;
            data_q  <= data_d;
        end
    end

    // Outputs decode straight from state so o_mem_req drops with an asynchronous reset
    assign bus.o_instr_ready = (state_q == S_FETCH) && !bus.i_hold;
    assign bus.o_pc          = pc_q;
    assign bus.o_mem_req     = (state_q == S_MEMACC);
    assign bus.o_mem_we      = (op_q == OP_ST);
    assign bus.o_mem_addr    = addr;
    assign bus.o_mem_wdata   = a_q;
    assign bus.o_wait        = (state_q != S_FETCH);
    assign bus.o_halted      = (state_q == S_HALT);
    assign bus.o_data        = data_q;
endmodule

// File: tb/tb_cpu_core_mc.sv
// Bench for cpu_core_mc: directed vector table, hand sequences for hold/reset/halt,
// then random instructions checked against an instruction-level reference model.
module tb_cpu_core_mc;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned NREGS  = 8;
    localparam int unsigned ADDR_W = 16;

    typedef struct {
        logic [7:0]  opc, d1, d2;
        int          dly;
        bit          hold, halt;
        logic [15:0] pc;
        logic [7:0]  data;
        int          lat;
        bit          acc, we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        bit          z, c;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [7:0] env_mem [int];
    int         m_regs [16];
    int         m_pc, m_ra, m_data;
    bit         m_z, m_c;
    int         m_mem [int];

    always #5 clk = ~clk;

    cpu_core_mc_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    cpu_core_mc #(.DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] opc, d1, d2, input int dly, input bit hold,
                                input logic [15:0] pc, input logic [7:0] data, input int lat,
                                input bit acc, we, input logic [15:0] addr,
                                input logic [7:0] wdata, input bit z, c);
        vec_t v;
        v.opc = opc; v.d1 = d1; v.d2 = d2; v.dly = dly; v.hold = hold; v.halt = 1'b0;
        v.pc = pc; v.data = data; v.lat = lat; v.acc = acc; v.we = we; v.addr = addr;
        v.wdata = wdata; v.z = z; v.c = c;
        return v;
    endfunction

    function automatic logic [7:0] env_rd(input logic [15:0] a);
        return env_mem.exists(int'(a)) ? env_mem[int'(a)] : 8'h00;
    endfunction

    task automatic do_reset();
        bus.i_instr_valid = 1'b0;
        bus.i_hold        = 1'b0;
        bus.i_mem_ready   = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // Issue one instruction, play the memory side, and check the outcome
    task automatic run_vec(input vec_t v, input string tag);
        int  lat, macc;
        bit  done, saw;
        bus.i_opcode = v.opc; bus.i_data1 = v.d1; bus.i_data2 = v.d2;
        bus.i_instr_valid = 1'b1;
        #1;
        chk({tag, " instr_ready"}, 32'(bus.o_instr_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.i_instr_valid = 1'b0;
        bus.i_opcode = 8'($urandom); bus.i_data1 = 8'($urandom); bus.i_data2 = 8'($urandom);
        if (v.hold) bus.i_hold = 1'b1;
        lat = 1; macc = 0; done = 1'b0; saw = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (bus.o_mem_req) begin
                saw = 1'b1;
                if (v.acc) begin
                    chk({tag, " mem_addr"}, 32'(bus.o_mem_addr), 32'(v.addr));
                    chk({tag, " mem_we"}, 32'(bus.o_mem_we), 32'(v.we));
                    if (v.we) chk({tag, " mem_wdata"}, 32'(bus.o_mem_wdata), 32'(v.wdata));
                end
                if (macc == v.dly) begin
                    bus.i_mem_ready = 1'b1;
                    bus.i_mem_rdata = env_rd(bus.o_mem_addr);
                    if (bus.o_mem_we) env_mem[int'(bus.o_mem_addr)] = bus.o_mem_wdata;
                end else begin
                    bus.i_mem_ready = 1'b0;
                    bus.i_mem_rdata = 8'($urandom);
                end
                macc++;
            end else begin
                bus.i_mem_ready = 1'b0;
            end
            if (!bus.o_wait || bus.o_halted) done = 1'b1;
            else lat++;
        end
        bus.i_hold = 1'b0;
        chk({tag, " latency"}, 32'(lat), 32'(v.lat));
        chk({tag, " mem_access"}, 32'(saw), 32'(v.acc));
        chk({tag, " pc"}, 32'(bus.o_pc), 32'(v.pc));
        chk({tag, " data"}, 32'(bus.o_data), 32'(v.data));
        chk({tag, " halted"}, 32'(bus.o_halted), 32'(v.halt));
        chk({tag, " z"}, 32'(dut.z_q), 32'(v.z));
        chk({tag, " c"}, 32'(dut.c_q), 32'(v.c));
    endtask

    // Instruction-level reference: applies one instruction to the model state
    function automatic vec_t model_step(input logic [7:0] opc, d1, d2, input int dly);
        vec_t v;
        int op, rd, rs, adr, r, npc;
        bit bad;
        op = int'(opc[7:4]); rd = int'(opc[3:0]); rs = int'(d1[3:0]); adr = int'({d2, d1});
        npc = (m_pc + 1) & 16'hFFFF;
        v = mk(opc, d1, d2, dly, 1'b0, 16'h0, 8'h0, 4, 1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
        bad = (op >= 1 && op <= 10 && rd >= int'(NREGS)) ||
              (op >= 2 && op <= 7 && rs >= int'(NREGS));
        if (!bad) begin
            case (op)
                1: m_regs[rd] = int'(d1);
                2: m_regs[rd] = m_regs[rs];
                3: begin
                    r = m_regs[rd] + m_regs[rs];
                    m_c = (r > 255); m_regs[rd] = r & 255; m_z = (m_regs[rd] == 0);
                end
                4: begin
                    m_c = (m_regs[rd] < m_regs[rs]);
                    m_regs[rd] = (m_regs[rd] - m_regs[rs]) & 255; m_z = (m_regs[rd] == 0);
                end
                5: begin m_regs[rd] = m_regs[rd] & m_regs[rs]; m_z = (m_regs[rd] == 0); end
                6: begin m_regs[rd] = m_regs[rd] | m_regs[rs]; m_z = (m_regs[rd] == 0); end
                7: begin m_regs[rd] = m_regs[rd] ^ m_regs[rs]; m_z = (m_regs[rd] == 0); end
                8: begin
                    v.acc = 1'b1; v.we = 1'b0; v.addr = 16'(adr);
                    m_regs[rd] = m_mem.exists(adr) ? m_mem[adr] : 0;
                end
                9: begin
                    v.acc = 1'b1; v.we = 1'b1; v.addr = 16'(adr); v.wdata = 8'(m_regs[rd]);
                    m_mem[adr] = m_regs[rd];
                end
                10: m_data = m_regs[rd];
                11: npc = adr;
                12: if (m_z) npc = adr;
                13: begin m_ra = npc; npc = adr; end
                14: npc = m_ra;
                15: begin v.halt = 1'b1; npc = m_pc; end
                default: ;
            endcase
        end
        m_pc   = npc;
        v.pc   = 16'(m_pc);
        v.data = 8'(m_data);
        v.lat  = v.acc ? 5 + dly : 4;
        v.z    = m_z;
        v.c    = m_c;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required $finish earlier");
        $fatal(1);
    end

    initial begin
        vec_t tbl [$];
        vec_t v;
        bit   got;
        logic [7:0] opc, d1, d2;
        int   op, rd, rsv;

        rst_n = 1'b1;
        bus.i_hold = 1'b0; bus.i_instr_valid = 1'b0; bus.i_opcode = 8'h0;
        bus.i_data1 = 8'h0; bus.i_data2 = 8'h0; bus.i_mem_ready = 1'b0; bus.i_mem_rdata = 8'h0;
        #1;
        do_reset();
        chk("reset pc", 32'(bus.o_pc), 32'h0);
        chk("reset wait", 32'(bus.o_wait), 32'h0);
        chk("reset instr_ready", 32'(bus.o_instr_ready), 32'h1);
        chk("reset mem_req", 32'(bus.o_mem_req), 32'h0);
        chk("reset data", 32'(bus.o_data), 32'h0);
        chk("reset halted", 32'(bus.o_halted), 32'h0);

        //          opc    d1     d2     dly hold pc        data   lat acc we addr      wdata  z c
        tbl.push_back(mk(8'h11, 8'hFF, 8'h00, 0, 0, 16'h0001, 8'h00, 4, 0, 0, 16'h0000, 8'h00, 0, 0));
        tbl.push_back(mk(8'h12, 8'h01, 8'h00, 0, 0, 16'h0002, 8'h00, 4, 0, 0, 16'h0000, 8'h00, 0, 0));
        tbl.push_back(mk(8'h31, 8'h02, 8'h00, 0, 0, 16'h0003, 8'h00, 4, 0, 0, 16'h0000, 8'h00, 1, 1));
        tbl.push_back(mk(8'hA1, 8'h00, 8'h00, 0, 1, 16'h0004, 8'h00, 4, 0, 0, 16'h0000, 8'h00, 1, 1));
        tbl.push_back(mk(8'h11, 8'h5A, 8'h00, 0, 0, 16'h0005, 8'h00, 4, 0, 0, 16'h0000, 8'h00, 1, 1));
        tbl.push_back(mk(8'hD0, 8'h40, 8'h00, 0, 0, 16'h0040, 8'h00, 4, 0, 0, 16'h0000, 8'h00, 1, 1));
        tbl.push_back(mk(8'h91, 8'h10, 8'h00, 3, 0, 16'h0041, 8'h00, 8, 1, 1, 16'h0010, 8'h5A, 1, 1));
        tbl.push_back(mk(8'h83, 8'h10, 8'h00, 0, 0, 16'h0042, 8'h00, 5, 1, 0, 16'h0010, 8'h00, 1, 1));
        tbl.push_back(mk(8'hA3, 8'h00, 8'h00, 0, 0, 16'h0043, 8'h5A, 4, 0, 0, 16'h0000, 8'h00, 1, 1));
        tbl.push_back(mk(8'hE0, 8'h00, 8'h00, 0, 0, 16'h0006, 8'h5A, 4, 0, 0, 16'h0000, 8'h00, 1, 1));
        tbl.push_back(mk(8'h51, 8'h01, 8'h00, 0, 0, 16'h0007, 8'h5A, 4, 0, 0, 16'h0000, 8'h00, 0, 1));
        tbl.push_back(mk(8'hC0, 8'h80, 8'h00, 0, 0, 16'h0008, 8'h5A, 4, 0, 0, 16'h0000, 8'h00, 0, 1));
        tbl.push_back(mk(8'h42, 8'h01, 8'h00, 0, 0, 16'h0009, 8'h5A, 4, 0, 0, 16'h0000, 8'h00, 0, 1));
        tbl.push_back(mk(8'hA2, 8'h00, 8'h00, 0, 0, 16'h000A, 8'hA7, 4, 0, 0, 16'h0000, 8'h00, 0, 1));
        tbl.push_back(mk(8'h72, 8'h02, 8'h00, 0, 0, 16'h000B, 8'hA7, 4, 0, 0, 16'h0000, 8'h00, 1, 1));
        tbl.push_back(mk(8'hC0, 8'h20, 8'h00, 0, 0, 16'h0020, 8'hA7, 4, 0, 0, 16'h0000, 8'h00, 1, 1));
        tbl.push_back(mk(8'h19, 8'h33, 8'h00, 0, 0, 16'h0021, 8'hA7, 4, 0, 0, 16'h0000, 8'h00, 1, 1));
        tbl.push_back(mk(8'h23, 8'h0C, 8'h00, 0, 0, 16'h0022, 8'hA7, 4, 0, 0, 16'h0000, 8'h00, 1, 1));
        tbl.push_back(mk(8'hA3, 8'h00, 8'h00, 0, 0, 16'h0023, 8'h5A, 4, 0, 0, 16'h0000, 8'h00, 1, 1));
        tbl.push_back(mk(8'h33, 8'h03, 8'h00, 0, 0, 16'h0024, 8'h5A, 4, 0, 0, 16'h0000, 8'h00, 0, 0));
        tbl.push_back(mk(8'hA3, 8'h00, 8'h00, 0, 0, 16'h0025, 8'hB4, 4, 0, 0, 16'h0000, 8'h00, 0, 0));
        tbl.push_back(mk(8'hB0, 8'hFF, 8'hFF, 0, 0, 16'hFFFF, 8'hB4, 4, 0, 0, 16'h0000, 8'h00, 0, 0));
        tbl.push_back(mk(8'h00, 8'h00, 8'h00, 0, 0, 16'h0000, 8'hB4, 4, 0, 0, 16'h0000, 8'h00, 0, 0));
        foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl[%0d]", i));

        // Hold in FETCH blocks the accept even with a valid instruction waiting
        bus.i_hold = 1'b1; bus.i_instr_valid = 1'b1;
        bus.i_opcode = 8'h11; bus.i_data1 = 8'h77; bus.i_data2 = 8'h00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold instr_ready", 32'(bus.o_instr_ready), 32'h0);
            chk("hold wait", 32'(bus.o_wait), 32'h0);
            chk("hold pc", 32'(bus.o_pc), 32'h0);
        end
        bus.i_hold = 1'b0; bus.i_instr_valid = 1'b0;

        // Reset while a store waits in MEMACC
        bus.i_opcode = 8'h91; bus.i_data1 = 8'h30; bus.i_data2 = 8'h00;
        bus.i_instr_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.i_instr_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (bus.o_mem_req) got = 1'b1;
        end
        chk("rst_memacc reached", 32'(got), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_memacc mem_req", 32'(bus.o_mem_req), 32'h0);
        chk("rst_memacc wait", 32'(bus.o_wait), 32'h0);
        chk("rst_memacc pc", 32'(bus.o_pc), 32'h0);
        chk("rst_memacc data", 32'(bus.o_data), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_memacc instr_ready", 32'(bus.o_instr_ready), 32'h1);

        // HALT holds until reset, ignoring offered instructions
        v = mk(8'hF0, 8'h00, 8'h00, 0, 0, 16'h0000, 8'h00, 4, 0, 0, 16'h0000, 8'h00, 0, 0);
        v.halt = 1'b1;
        run_vec(v, "halt");
        bus.i_instr_valid = 1'b1; bus.i_opcode = 8'h11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("halt halted", 32'(bus.o_halted), 32'h1);
            chk("halt wait", 32'(bus.o_wait), 32'h1);
            chk("halt instr_ready", 32'(bus.o_instr_ready), 32'h0);
            chk("halt pc", 32'(bus.o_pc), 32'h0);
        end
        do_reset();
        chk("halt cleared by reset", 32'(bus.o_halted), 32'h0);

        // Random instructions against the reference model
        foreach (m_regs[i]) m_regs[i] = 0;
        m_pc = 0; m_ra = 0; m_data = 0; m_z = 1'b0; m_c = 1'b0;
        m_mem.delete();
        env_mem.delete();
        for (int n = 0; n < 300; n++) begin
            op  = (n == 299) ? 15 : int'($urandom_range(0, 14));
            rd  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 15))
                                               : int'($urandom_range(0, 7));
            rsv = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 15))
                                               : int'($urandom_range(0, 7));
            opc = {4'(op), 4'(rd)};
            d2  = 8'h00;
            if (op >= 2 && op <= 7)      d1 = {4'($urandom_range(0, 15)), 4'(rsv)};
            else if (op == 8 || op == 9) d1 = 8'($urandom_range(0, 15));
            else                         d1 = 8'($urandom);
            if (op >= 11 && op <= 13)    d2 = 8'($urandom_range(0, 1));
            v = model_step(opc, d1, d2, int'($urandom_range(0, 3)));
            v.hold = 1'($urandom_range(0, 1));
            run_vec(v, $sformatf("rnd[%0d] op%0h", n, op));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
